// File: rtl/dcpu_alu_seq_if.sv
// Handshake and result bus between operand decode and the DCPU ALU.
// master drives operations in and slave returns completions.
interface dcpu_alu_seq_if #(parameter int WIDTH = 16) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] overflow;
  logic             overflow_we;
  logic             cond;

  modport master (
    output in_valid, opcode, a, b,
    input  in_ready, out_valid, result, overflow, overflow_we, cond
  );

  modport slave (
    input  in_valid, opcode, a, b,
    output in_ready, out_valid, result, overflow, overflow_we, cond
  );
endinterface

// File: rtl/dcpu_alu_seq.sv
// Multi-cycle DCPU-16 ALU: single-cycle basic ops plus iterative shift-add MUL
// and restoring DIV/MOD behind a valid/ready handshake.
module dcpu_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  dcpu_alu_seq_if.slave  io
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(2*W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_MOD} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, mcand, dq;
  logic [W-1:0]   mplier, dvs, rem;

  // Single-cycle result set, also covers divide-by-zero and opcode 0.
  logic [W-1:0]   s_res, s_ovf;
  logic           s_we, s_cond;
  logic [2*W-1:0] t;

  always_comb begin
    s_res  = '0;
    s_ovf  = '0;
    s_we   = 1'b0;
    s_cond = 1'b0;
    t      = '0;
    case (io.opcode)
      4'h1: s_res = io.b;
      4'h2: begin
        t     = {{W{1'b0}}, io.a} + {{W{1'b0}}, io.b};
        s_res = t[W-1:0];
        s_ovf = t[2*W-1:W];
        s_we  = 1'b1;
      end
      4'h3: begin
        s_res = io.a - io.b;
        s_ovf = (io.a < io.b) ? {W{1'b1}} : '0;
        s_we  = 1'b1;
      end
      4'h5: s_we = 1'b1;
      4'h7: begin
        t     = {{W{1'b0}}, io.a} << io.b;
        s_res = t[W-1:0];
        s_ovf = t[2*W-1:W];
        s_we  = 1'b1;
      end
      4'h8: begin
        t     = {io.a, {W{1'b0}}} >> io.b;
        s_res = io.a >> io.b;
        s_ovf = t[W-1:0];
        s_we  = 1'b1;
      end
      4'h9: s_res = io.a & io.b;
      4'hA: s_res = io.a | io.b;
      4'hB: s_res = io.a ^ io.b;
      4'hC: begin s_res = io.a; s_cond = (io.a == io.b);       end
      4'hD: begin s_res = io.a; s_cond = (io.a != io.b);       end
      4'hE: begin s_res = io.a; s_cond = (io.a >  io.b);       end
      4'hF: begin s_res = io.a; s_cond = ((io.a & io.b) != '0); end
      default: ;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide.
  logic [2*W-1:0] acc_n, dq_n;
  logic [W:0]     sh, diff;
  logic           ge;
  logic [W-1:0]   rem_n;

  always_comb begin
    acc_n = acc + (mplier[0] ? mcand : '0);
    sh    = {rem, dq[2*W-1]};
    diff  = sh - {1'b0, dvs};
    ge    = (sh >= {1'b0, dvs});
    rem_n = ge ? diff[W-1:0] : sh[W-1:0];
    dq_n  = {dq[2*W-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      dq             <= '0;
      dvs            <= '0;
      rem            <= '0;
      io.in_ready    <= 1'b1;
      io.out_valid   <= 1'b0;
      io.result      <= '0;
      io.overflow    <= '0;
      io.overflow_we <= 1'b0;
      io.cond        <= 1'b0;
    end else begin
      io.out_valid <= 1'b0;
      case (state)
        S_IDLE: if (io.in_valid) begin
          cnt <= '0;
          if (io.opcode == 4'h4) begin
            state       <= S_MUL;
            io.in_ready <= 1'b0;
            acc         <= '0;
            mcand       <= {{W{1'b0}}, io.a};
            mplier      <= io.b;
          end else if ((io.opcode == 4'h5 || io.opcode == 4'h6) && io.b != '0) begin
            // DIV divides a<<W for 2W quotient bits; MOD stops after a's W bits.
            state       <= (io.opcode == 4'h5) ? S_DIV : S_MOD;
            io.in_ready <= 1'b0;
            dq          <= {io.a, {W{1'b0}}};
            rem         <= '0;
            dvs         <= io.b;
          end else begin
            io.out_valid   <= 1'b1;
            io.result      <= s_res;
            io.overflow    <= s_ovf;
            io.overflow_we <= s_we;
            io.cond        <= s_cond;
          end
        end
        S_MUL: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            state          <= S_IDLE;
            io.in_ready    <= 1'b1;
            io.out_valid   <= 1'b1;
            io.result      <= acc_n[W-1:0];
            io.overflow    <= acc_n[2*W-1:W];
            io.overflow_we <= 1'b1;
            io.cond        <= 1'b0;
          end
        end
        S_DIV: begin
          dq  <= dq_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(2*W-1)) begin
            state          <= S_IDLE;
            io.in_ready    <= 1'b1;
            io.out_valid   <= 1'b1;
            io.result      <= dq_n[2*W-1:W];
            io.overflow    <= dq_n[W-1:0];
            io.overflow_we <= 1'b1;
            io.cond        <= 1'b0;
          end
        end
        S_MOD: begin
          dq  <= dq_n;
          rem <= rem_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            state          <= S_IDLE;
            io.in_ready    <= 1'b1;
            io.out_valid   <= 1'b1;
            io.result      <= rem_n;
            io.overflow    <= '0;
            io.overflow_we <= 1'b0;
            io.cond        <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcpu_alu_seq.sv
// Bench for dcpu_alu_seq: directed cases plus random ops against an
// arithmetic reference model of the DCPU basic opcodes.
module tb_dcpu_alu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dcpu_alu_seq_if #(.WIDTH(W)) io ();
  dcpu_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .io(io));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [15:0] o,
                                output logic we, output logic c, output int lat);
    longint unsigned la = 64'(a), lb = 64'(b), t;
    r = '0; o = '0; we = 1'b0; c = 1'b0; lat = 1;
    case (op)
      4'h1: r = b;
      4'h2: begin t = la + lb; r = t[15:0]; o = t[31:16]; we = 1'b1; end
      4'h3: begin r = a - b; o = (a < b) ? 16'hFFFF : 16'h0000; we = 1'b1; end
      4'h4: begin t = la * lb; r = t[15:0]; o = t[31:16]; we = 1'b1; lat = W + 1; end
      4'h5: begin
        we = 1'b1;
        if (b != 0) begin t = (la << 16) / lb; r = t[31:16]; o = t[15:0]; lat = 2*W + 1; end
      end
      4'h6: if (b != 0) begin r = a % b; lat = W + 1; end
      4'h7: begin
        we = 1'b1;
        if (b < 32) begin t = la << b; r = t[15:0]; o = t[31:16]; end
      end
      4'h8: begin
        we = 1'b1;
        if (b < 32) begin t = la >> b; r = t[15:0]; t = (la << 16) >> b; o = t[15:0]; end
      end
      4'h9: r = a & b;
      4'hA: r = a | b;
      4'hB: r = a ^ b;
      4'hC: begin r = a; c = (a == b); end
      4'hD: begin r = a; c = (a != b); end
      4'hE: begin r = a; c = (a > b); end
      4'hF: begin r = a; c = ((a & b) != 0); end
      default: ;
    endcase
  endfunction

  // Issue one op, optionally poke in_valid while busy, and check the completion.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit noise);
    logic [15:0] er, eo;
    logic ewe, ec;
    int elat, lat;
    bit busy_ok;
    model(op, a, b, er, eo, ewe, ec, elat);
    @(negedge clk);
    for (int i = 0; i < 100 && !io.in_ready; i++) @(negedge clk);
    io.in_valid = 1'b1; io.opcode = op; io.a = a; io.b = b;
    @(posedge clk); #1;
    io.in_valid = 1'b0; io.opcode = 4'($urandom); io.a = 16'($urandom); io.b = 16'($urandom);
    lat = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 2*W + 8; n++) begin
      @(negedge clk);
      if (io.out_valid) begin lat = n; break; end
      if (io.in_ready) busy_ok = 1'b0;
      if (noise && n < elat) begin
        io.in_valid = 1'($urandom_range(0, 1));
        io.opcode   = 4'($urandom_range(1, 15));
        io.a        = 16'($urandom);
        io.b        = 16'($urandom);
      end else io.in_valid = 1'b0;
    end
    io.in_valid = 1'b0;
    chk($sformatf("lat op%h", op), lat, elat);
    chk($sformatf("result op%h a=%h b=%h", op, a, b), {16'h0, io.result}, {16'h0, er});
    chk($sformatf("overflow op%h a=%h b=%h", op, a, b), {16'h0, io.overflow}, {16'h0, eo});
    chk($sformatf("overflow_we op%h", op), {31'h0, io.overflow_we}, {31'h0, ewe});
    chk($sformatf("cond op%h a=%h b=%h", op, a, b), {31'h0, io.cond}, {31'h0, ec});
    chk($sformatf("busy_ready op%h", op), {31'h0, busy_ok}, 32'h1);
    chk("ready_at_done", {31'h0, io.in_ready}, 32'h1);
    @(negedge clk);
    chk("no_extra_valid", {31'h0, io.out_valid}, 32'h0);
  endtask

  initial begin
    bit quiet;
    logic [3:0] rop;
    logic [15:0] ra, rb;
    io.in_valid = 1'b0; io.opcode = '0; io.a = '0; io.b = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", {31'h0, io.in_ready}, 32'h1);
    chk("rst out_valid", {31'h0, io.out_valid}, 32'h0);
    chk("rst result", {16'h0, io.result}, 32'h0);
    chk("rst overflow", {16'h0, io.overflow}, 32'h0);
    chk("rst overflow_we/cond", {30'h0, io.overflow_we, io.cond}, 32'h0);
    rst = 1'b0;

    // ADD then SUB back-to-back, one per clock.
    @(negedge clk);
    io.in_valid = 1'b1; io.opcode = 4'h2; io.a = 16'hFFFF; io.b = 16'h0002;
    @(posedge clk); #1;
    io.opcode = 4'h3; io.a = 16'h0001; io.b = 16'h0002;
    @(negedge clk);
    chk("b2b add valid", {31'h0, io.out_valid}, 32'h1);
    chk("b2b add result", {16'h0, io.result}, 32'h0001);
    chk("b2b add overflow", {15'h0, io.overflow_we, io.overflow}, 32'h1_0001);
    chk("b2b ready", {31'h0, io.in_ready}, 32'h1);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b sub valid", {31'h0, io.out_valid}, 32'h1);
    chk("b2b sub result", {16'h0, io.result}, 32'hFFFF);
    chk("b2b sub overflow", {15'h0, io.overflow_we, io.overflow}, 32'h1_FFFF);

    run_op(4'h4, 16'h1234, 16'h5678, 1'b1);
    run_op(4'h5, 16'h0007, 16'h0002, 1'b1);
    run_op(4'h5, 16'h0007, 16'h0000, 1'b0);
    run_op(4'h6, 16'h0007, 16'h0003, 1'b1);
    run_op(4'h6, 16'h0007, 16'h0000, 1'b0);
    run_op(4'h8, 16'h8001, 16'h0001, 1'b0);
    run_op(4'h7, 16'h8001, 16'h0001, 1'b0);
    run_op(4'h7, 16'h0001, 16'h0020, 1'b0);
    run_op(4'h8, 16'h8001, 16'h001F, 1'b0);
    run_op(4'hE, 16'h0005, 16'h0003, 1'b0);
    run_op(4'hF, 16'h00F0, 16'h000F, 1'b0);
    run_op(4'h0, 16'h1234, 16'h5678, 1'b0);
    run_op(4'h5, 16'hFFFF, 16'h0001, 1'b0);

    for (int k = 0; k < 80; k++) begin
      rop = 4'($urandom);
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    // Abort a DIV mid-flight with reset.
    @(negedge clk);
    io.in_valid = 1'b1; io.opcode = 4'h5; io.a = 16'h1234; io.b = 16'h0003;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort in_ready", {31'h0, io.in_ready}, 32'h1);
    chk("abort outputs", {io.result, io.overflow}, 32'h0);
    chk("abort flags", {30'h0, io.overflow_we, io.cond}, 32'h0);
    chk("abort out_valid", {31'h0, io.out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int n = 0; n < 2*W + 8; n++) begin
      @(negedge clk);
      if (io.out_valid) quiet = 1'b0;
    end
    chk("abort no out_valid", {31'h0, quiet}, 32'h1);
    run_op(4'h2, 16'h0001, 16'h0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
